gearbox_2_to_1: RTL and testbench
=================================

GEARBOX_2_TO_1 -- requirements
Module: gearbox_2_to_1

Interface
REQ-001 The block SHALL have parameter `width`, default 8, giving the downstream word width in bits; legal values are 1 or more.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port `up_vld`, input, 1 bit: upstream word valid.
REQ-005 The block SHALL have port `up_data`, input, 2*width bits: upstream double-width word.
REQ-006 The block SHALL have port `up_rdy`, output, 1 bit: block accepts `up_data` this cycle.
REQ-007 The block SHALL have port `down_vld`, output, 1 bit: downstream half-word valid.
REQ-008 The block SHALL have port `down_data`, output, width bits: downstream half-word.
REQ-009 The block SHALL have port `down_rdy`, input, 1 bit: downstream consumer accepts `down_data` this cycle.

Function
REQ-010 An upstream transfer SHALL occur in a cycle where both `up_vld` and `up_rdy` are 1.
REQ-011 A downstream transfer SHALL occur in a cycle where both `down_vld` and `down_rdy` are 1.
REQ-012 Each accepted word SHALL be emitted as two downstream transfers: `up_data[2*width-1:width]` first, then `up_data[width-1:0]`, the inverse of the {first, second} packing of the 1-to-2 gearbox.
REQ-013 The block SHALL hold a 2*width-bit register plus a state machine with states EMPTY, HIGH (upper half pending) and LOW (lower half pending).
REQ-014 `down_vld` SHALL be 1 exactly when the state is HIGH or LOW.
REQ-015 `down_data` SHALL be the upper half of the register in HIGH, the lower half in LOW, and all zeros in EMPTY.
REQ-016 `up_rdy` SHALL be 1 when the state is EMPTY, or when the state is LOW and `down_rdy` is 1 (the last half leaves this cycle); otherwise it SHALL be 0.
REQ-017 The state machine transitions SHALL be:
  - EMPTY: upstream transfer -> HIGH, loads register; otherwise stays EMPTY.
  - HIGH: downstream transfer -> LOW; otherwise stays HIGH, register unchanged.
  - LOW: downstream transfer together with upstream transfer -> HIGH, loads new word.
  - LOW: downstream transfer without upstream transfer -> EMPTY.
  - LOW: no downstream transfer -> stays LOW, `up_rdy` is 0.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N presents its upper half on `down_data`/`down_vld` in the cycle after edge N.
REQ-019 With `up_vld` and `down_rdy` continuously 1, the block SHALL sustain one downstream transfer every cycle and one upstream transfer every second cycle, with no bubble between words.
REQ-020 Backpressure (`down_rdy` = 0) SHALL hold `down_data`, `down_vld` and the register stable and SHALL never drop or duplicate a half-word.
REQ-021 `up_data` SHALL be ignored in any cycle without an upstream transfer.
REQ-022 `up_rdy` SHALL depend combinationally only on the state and `down_rdy`, never on `up_vld`.
REQ-023 `down_vld` and `down_data` SHALL depend only on registered state and register contents, with no combinational path from any input.

Reset
REQ-024 While `rst` = 1 at a rising edge, the state SHALL become EMPTY and the register SHALL become all zeros.
REQ-025 While `rst` = 1, `up_rdy` SHALL be forced to 0, so no transfer is accepted during reset.
REQ-026 After reset, `down_vld` = 0 and `down_data` = 0 SHALL hold until the first upstream transfer.
REQ-027 Reset asserted in HIGH or LOW SHALL discard any pending half-words; none SHALL appear after `rst` deasserts.

Verification (width = 8)
REQ-028 Single word, full rate: `up_data` = 16'hA55A accepted, `down_rdy` = 1 -> next two cycles `down_data` = 8'hA5 then 8'h5A with `down_vld` = 1, then `down_vld` = 0 and `down_data` = 0.
REQ-029 Streaming: `up_vld` = 1 with words 16'h0102, 16'h0304, 16'h0506, `down_rdy` = 1 -> `down_data` = 01,02,03,04,05,06 on consecutive cycles; `up_rdy` toggles 1,0,1,0,...
REQ-030 Backpressure: 16'hBEEF accepted, `down_rdy` = 0 for 3 cycles -> `down_data` holds 8'hBE with `up_rdy` = 0; after `down_rdy` returns to 1, the outputs are BE then EF, with none lost.
REQ-031 LOW stall: `down_rdy` = 0 while in LOW with `up_vld` = 1 -> `up_rdy` = 0 and the new word is not taken; the lower half is emitted first when `down_rdy` = 1.
REQ-032 Mid-operation reset: `rst` pulsed for 1 cycle in HIGH after 16'h1234 was accepted -> `down_vld` = 0 and `down_data` = 0 next cycle, and 8'h34 is never emitted.
REQ-033 Random traffic: random `up_vld`/`down_rdy`, checked against a FIFO reference model -> the output half-word sequence exactly matches the upper/lower splits of the accepted words, in order.

Source files
------------

// File: rtl/gearbox_2_to_1.sv
// gearbox_2_to_1: splits each accepted double-width upstream word into two
// downstream half-words, upper half first, with valid/ready handshakes on
// both sides and one-cycle latency.
//
// state | meaning
// EMPTY | no half-word pending, ready for a new word
// HIGH  | upper half of the held word on down_data
// LOW   | lower half of the held word on down_data
module gearbox_2_to_1 #(
   parameter int width = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_vld,
   input  logic [2*width-1:0] up_data,
   output logic               up_rdy,
   output logic               down_vld,
   output logic [width-1:0]   down_data,
   input  logic               down_rdy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [2*width-1:0] word;
   logic               up_xfer;
   logic               down_xfer;

   // Handshakes; up_rdy looks only at state and down_rdy so a word can be
   // taken in the same cycle the last half leaves, and is held low in reset.
   always_comb begin
      up_rdy    = 1'b0;
      down_vld  = 1'b0;
      down_xfer = 1'b0;
      up_xfer   = 1'b0;
      if (!rst) begin
         up_rdy = (state == EMPTY) || ((state == LOW) && down_rdy);
      end
      down_vld  = (state == HIGH) || (state == LOW);
      down_xfer = down_vld && down_rdy;
      up_xfer   = up_vld && up_rdy;
   end

   // Downstream half selection, driven from registered state only.
   always_comb begin
      down_data = '0;
      case (state)
         HIGH:    down_data = word[2*width-1:width];
         LOW:     down_data = word[width-1:0];
         default: down_data = '0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (up_xfer) begin
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (down_xfer) begin
               state_nxt = LOW;
            end
         end
         LOW: begin
            if (down_xfer) begin
               state_nxt = up_xfer ? HIGH : EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Word register: loads only on an upstream transfer, otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
      end else if (up_xfer) begin
         word <= up_data;
      end
   end

endmodule

// File: tb/tb_gearbox_2_to_1.sv
// Directed bench for gearbox_2_to_1 (width 8) with a short random-traffic
// section checked against a half-word queue model.
module tb_gearbox_2_to_1;

   logic        clk;
   logic        rst;
   logic        up_vld;
   logic [15:0] up_data;
   logic        up_rdy;
   logic        down_vld;
   logic [7:0]  down_data;
   logic        down_rdy;

   int vectors;
   int miscompares;

   logic [7:0] exp_q[$];

   gearbox_2_to_1 #(.width(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .up_vld    (up_vld),
      .up_data   (up_data),
      .up_rdy    (up_rdy),
      .down_vld  (down_vld),
      .down_data (down_data),
      .down_rdy  (down_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic vld, input logic [7:0] data,
                          input logic rdy);
      #1;
      chk({tag, ".down_vld"}, {31'd0, down_vld}, {31'd0, vld});
      chk({tag, ".down_data"}, {24'd0, down_data}, {24'd0, data});
      chk({tag, ".up_rdy"}, {31'd0, up_rdy}, {31'd0, rdy});
   endtask

   task automatic drive(input logic vld, input logic [15:0] data, input logic rdy);
      up_vld   = vld;
      up_data  = data;
      down_rdy = rdy;
   endtask

   initial begin
      logic       m_up_rdy;
      logic       m_vld;
      logic [7:0] m_data;

      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      drive(1'b1, 16'hDEAD, 1'b1);
      tick();
      tick();
      // reset: nothing accepted, outputs idle
      chk_out("reset", 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b1);
      chk_out("post_reset", 1'b0, 8'h00, 1'b1);

      // single word at full rate
      drive(1'b1, 16'hA55A, 1'b1);
      chk_out("single.accept", 1'b0, 8'h00, 1'b1);
      tick();
      drive(1'b0, 16'hFFFF, 1'b1);
      chk_out("single.high", 1'b1, 8'hA5, 1'b0);
      tick();
      chk_out("single.low", 1'b1, 8'h5A, 1'b1);
      tick();
      chk_out("single.empty", 1'b0, 8'h00, 1'b1);

      // streaming three words back to back
      drive(1'b1, 16'h0102, 1'b1);
      chk_out("stream.0", 1'b0, 8'h00, 1'b1);
      tick();
      drive(1'b1, 16'h0304, 1'b1);
      chk_out("stream.1", 1'b1, 8'h01, 1'b0);
      tick();
      chk_out("stream.2", 1'b1, 8'h02, 1'b1);
      tick();
      drive(1'b1, 16'h0506, 1'b1);
      chk_out("stream.3", 1'b1, 8'h03, 1'b0);
      tick();
      chk_out("stream.4", 1'b1, 8'h04, 1'b1);
      tick();
      drive(1'b0, 16'h0000, 1'b1);
      chk_out("stream.5", 1'b1, 8'h05, 1'b0);
      tick();
      chk_out("stream.6", 1'b1, 8'h06, 1'b1);
      tick();
      chk_out("stream.7", 1'b0, 8'h00, 1'b1);

      // backpressure in HIGH
      drive(1'b1, 16'hBEEF, 1'b0);
      chk_out("bp.accept", 1'b0, 8'h00, 1'b1);
      tick();
      drive(1'b1, 16'h7777, 1'b0);
      chk_out("bp.hold0", 1'b1, 8'hBE, 1'b0);
      tick();
      chk_out("bp.hold1", 1'b1, 8'hBE, 1'b0);
      tick();
      chk_out("bp.hold2", 1'b1, 8'hBE, 1'b0);
      drive(1'b0, 16'h7777, 1'b1);
      chk_out("bp.release", 1'b1, 8'hBE, 1'b0);
      tick();

      // stall in LOW with a new word waiting
      drive(1'b1, 16'hCAFE, 1'b0);
      chk_out("lowstall.0", 1'b1, 8'hEF, 1'b0);
      tick();
      chk_out("lowstall.1", 1'b1, 8'hEF, 1'b0);
      drive(1'b1, 16'hCAFE, 1'b1);
      chk_out("lowstall.release", 1'b1, 8'hEF, 1'b1);
      tick();
      drive(1'b0, 16'h0000, 1'b1);
      chk_out("lowstall.hi", 1'b1, 8'hCA, 1'b0);
      tick();
      chk_out("lowstall.lo", 1'b1, 8'hFE, 1'b1);
      tick();
      chk_out("lowstall.empty", 1'b0, 8'h00, 1'b1);

      // reset while HIGH discards the lower half
      drive(1'b1, 16'h1234, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      chk_out("rst_high.pre", 1'b1, 8'h12, 1'b0);
      rst = 1'b1;
      chk_out("rst_high.in_reset", 1'b1, 8'h12, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b1);
      chk_out("rst_high.after", 1'b0, 8'h00, 1'b1);
      tick();
      chk_out("rst_high.no34", 1'b0, 8'h00, 1'b1);

      // reset while LOW discards the lower half
      drive(1'b1, 16'h5678, 1'b1);
      tick();
      drive(1'b0, 16'h0000, 1'b1);
      chk_out("rst_low.hi", 1'b1, 8'h56, 1'b0);
      tick();
      chk_out("rst_low.lo", 1'b1, 8'h78, 1'b1);
      drive(1'b1, 16'h9999, 1'b0);
      rst = 1'b1;
      chk_out("rst_low.in_reset", 1'b1, 8'h78, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b0);
      chk_out("rst_low.after", 1'b0, 8'h00, 1'b1);

      // random traffic against a half-word queue model
      exp_q.delete();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
         m_vld    = (exp_q.size() != 0);
         m_data   = m_vld ? exp_q[0] : 8'h00;
         m_up_rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && down_rdy);
         chk_out("random", m_vld, m_data, m_up_rdy);
         if (m_vld && down_rdy) begin
            void'(exp_q.pop_front());
         end
         if (up_vld && m_up_rdy) begin
            exp_q.push_back(up_data[15:8]);
            exp_q.push_back(up_data[7:0]);
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
